// File: rtl/decode_issue_scoreboard.sv
// Decode/issue stage: decodes one MIPS instruction per cycle into a registered
// control word, tracks in-flight register writes with per-register counters,
// and stalls on RAW hazards or counter saturation until writeback retires.
module decode_issue_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [14:0] out_ctrl,
  output logic [3:0]  out_aluop,
  output logic [4:0]  out_dest,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic        flush,
  output logic        halted
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8, ALU_SRL = 4'd9, ALU_NONE = 4'hF
  } aluop_t;

  localparam int CB_REGWR = 0, CB_MEMRD = 1, CB_MEMWR = 2, CB_MEMTOREG = 3,
                 CB_ALUSRC = 4, CB_BRANCH = 5, CB_BNE = 6, CB_JUMP = 7,
                 CB_JR = 8, CB_JAL = 9, CB_LUI = 10, CB_SHIFT = 11,
                 CB_SIGNEXT = 12, CB_HALT = 13, CB_ILLEGAL = 14;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDIU = 6'h09,
                         OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30,
                         OP_SC = 6'h38, OP_HALT = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                         F_SLTU = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0]       op_p0, funct_p0;
  logic [4:0]       rs_p0, rt_p0, rd_p0, dest_p0;
  logic [14:0]      ctrl_p0;
  aluop_t           aluop_p0;
  logic             use_rs_p0, use_rt_p0, legal_p0, sext_p0;
  logic             haz_p0, sat_p0, in_fire;
  logic [31:0]      inc_vec, dec_vec;
  logic [CNT_W-1:0] cnt [32];

  assign op_p0    = in_instr[31:26];
  assign rs_p0    = in_instr[25:21];
  assign rt_p0    = in_instr[20:16];
  assign rd_p0    = in_instr[15:11];
  assign funct_p0 = in_instr[5:0];
  assign dest_p0  = (op_p0 == OP_RTYPE) ? rd_p0 : (op_p0 == OP_JAL) ? 5'd31 : rt_p0;

  // A source is busy while it has writes in flight, unless the only one retires now.
  function automatic logic src_busy(input logic [4:0] r, input logic [CNT_W-1:0] c,
                                    input logic wv, input logic [4:0] wr);
    return (r != 5'd0) && (c != '0) &&
           !(BYPASS_EN && wv && (wr == r) && (c == CNT_ONE));
  endfunction

  // Instruction decode into control word, aluop and source usage.
  always_comb begin
    ctrl_p0   = '0;
    aluop_p0  = ALU_NONE;
    use_rs_p0 = 1'b0;
    use_rt_p0 = 1'b0;
    legal_p0  = 1'b1;
    sext_p0   = 1'b1;
    case (op_p0)
      OP_RTYPE: begin
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
        ctrl_p0[CB_REGWR] = 1'b1;
        case (funct_p0)
          F_SLL:         begin aluop_p0 = ALU_SLL; ctrl_p0[CB_SHIFT] = 1'b1; use_rs_p0 = 1'b0; end
          F_SRL:         begin aluop_p0 = ALU_SRL; ctrl_p0[CB_SHIFT] = 1'b1; use_rs_p0 = 1'b0; end
          F_JR:          begin ctrl_p0[CB_REGWR] = 1'b0; ctrl_p0[CB_JR] = 1'b1; use_rt_p0 = 1'b0; end
          F_ADD, F_ADDU: aluop_p0 = ALU_ADD;
          F_SUB, F_SUBU: aluop_p0 = ALU_SUB;
          F_AND:         aluop_p0 = ALU_AND;
          F_OR:          aluop_p0 = ALU_OR;
          F_XOR:         aluop_p0 = ALU_XOR;
          F_NOR:         aluop_p0 = ALU_NOR;
          F_SLT:         aluop_p0 = ALU_SLT;
          F_SLTU:        aluop_p0 = ALU_SLTU;
          default:       legal_p0 = 1'b0;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        use_rs_p0 = 1'b1;
        ctrl_p0[CB_REGWR]  = 1'b1;
        ctrl_p0[CB_ALUSRC] = 1'b1;
        case (op_p0)
          OP_ADDIU: aluop_p0 = ALU_ADD;
          OP_SLTI:  aluop_p0 = ALU_SLT;
          OP_SLTIU: aluop_p0 = ALU_SLTU;
          OP_ANDI:  begin aluop_p0 = ALU_AND; sext_p0 = 1'b0; end
          OP_ORI:   begin aluop_p0 = ALU_OR;  sext_p0 = 1'b0; end
          default:  begin aluop_p0 = ALU_XOR; sext_p0 = 1'b0; end
        endcase
      end
      OP_LUI: begin
        ctrl_p0[CB_REGWR]  = 1'b1;
        ctrl_p0[CB_ALUSRC] = 1'b1;
        ctrl_p0[CB_LUI]    = 1'b1;
        aluop_p0 = ALU_OR;
        sext_p0  = 1'b0;
      end
      OP_LW, OP_LL: begin
        use_rs_p0 = 1'b1;
        ctrl_p0[CB_REGWR]    = 1'b1;
        ctrl_p0[CB_MEMRD]    = 1'b1;
        ctrl_p0[CB_MEMTOREG] = 1'b1;
        ctrl_p0[CB_ALUSRC]   = 1'b1;
        aluop_p0 = ALU_ADD;
      end
      OP_SW, OP_SC: begin
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
        ctrl_p0[CB_REGWR]  = (op_p0 == OP_SC);
        ctrl_p0[CB_MEMWR]  = 1'b1;
        ctrl_p0[CB_ALUSRC] = 1'b1;
        aluop_p0 = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
        ctrl_p0[CB_BRANCH] = 1'b1;
        ctrl_p0[CB_BNE]    = (op_p0 == OP_BNE);
        aluop_p0 = ALU_SUB;
      end
      OP_J:    ctrl_p0[CB_JUMP] = 1'b1;
      OP_JAL:  begin ctrl_p0[CB_JUMP] = 1'b1; ctrl_p0[CB_JAL] = 1'b1; ctrl_p0[CB_REGWR] = 1'b1; end
      OP_HALT: ctrl_p0[CB_HALT] = 1'b1;
      default: legal_p0 = 1'b0;
    endcase
    if (in_instr == 32'd0) begin
      ctrl_p0   = '0;
      aluop_p0  = ALU_NONE;
      use_rs_p0 = 1'b0;
      use_rt_p0 = 1'b0;
    end else if (!legal_p0) begin
      ctrl_p0   = '0;
      ctrl_p0[CB_ILLEGAL] = 1'b1;
      aluop_p0  = ALU_NONE;
      use_rs_p0 = 1'b0;
      use_rt_p0 = 1'b0;
    end else begin
      ctrl_p0[CB_SIGNEXT] = sext_p0;
    end
  end

  // Issue check: RAW hazard, counter saturation and downstream back-pressure.
  always_comb begin
    haz_p0 = (use_rs_p0 && src_busy(rs_p0, cnt[rs_p0], wb_valid, wb_reg)) ||
             (use_rt_p0 && src_busy(rt_p0, cnt[rt_p0], wb_valid, wb_reg));
    sat_p0 = ctrl_p0[CB_REGWR] && (cnt[dest_p0] == CNT_MAX) &&
             !(wb_valid && (wb_reg == dest_p0));
    in_ready = nRST && !flush && !halted && !haz_p0 && !sat_p0 && (!out_valid || out_ready);
    in_fire  = in_valid && in_ready;
    inc_vec  = '0;
    dec_vec  = '0;
    if (in_fire && ctrl_p0[CB_REGWR] && (dest_p0 != 5'd0)) inc_vec[dest_p0] = 1'b1;
    if (wb_valid && (wb_reg != 5'd0) && (cnt[wb_reg] != '0)) dec_vec[wb_reg] = 1'b1;
  end

  // Pending-write counters; a simultaneous issue and retire of one register cancel.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  // ---- stage boundary: decode -> output register ----
  // Output register with valid/ready hold and the sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_ctrl  <= '0;
      out_aluop <= '0;
      out_dest  <= '0;
      halted    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_ctrl  <= ctrl_p0;
      out_aluop <= aluop_p0;
      out_dest  <= dest_p0;
      if (ctrl_p0[CB_HALT]) halted <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed bench for decode_issue_scoreboard: a decode vector table plus
// hand-written hazard, saturation, hold, halt/flush and reset sequences.
module tb_decode_issue_scoreboard;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, out_ready, wb_valid, flush;
  logic [31:0] in_instr;
  logic [4:0]  wb_reg;
  logic        in_ready, out_valid, halted;
  logic [31:0] out_instr;
  logic [14:0] out_ctrl;
  logic [3:0]  out_aluop;
  logic [4:0]  out_dest;

  logic        nb_in_valid, nb_out_ready, nb_wb_valid, nb_flush;
  logic [31:0] nb_in_instr;
  logic [4:0]  nb_wb_reg;
  logic        nb_in_ready, nb_out_valid, nb_halted;
  logic [31:0] nb_out_instr;
  logic [14:0] nb_out_ctrl;
  logic [3:0]  nb_out_aluop;
  logic [4:0]  nb_out_dest;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decode_issue_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_ctrl(out_ctrl), .out_aluop(out_aluop),
    .out_dest(out_dest), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .halted(halted));

  decode_issue_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b0)) dut_nb (
    .CLK(CLK), .nRST(nRST), .in_valid(nb_in_valid), .in_instr(nb_in_instr),
    .in_ready(nb_in_ready), .out_valid(nb_out_valid), .out_ready(nb_out_ready),
    .out_instr(nb_out_instr), .out_ctrl(nb_out_ctrl), .out_aluop(nb_out_aluop),
    .out_dest(nb_out_dest), .wb_valid(nb_wb_valid), .wb_reg(nb_wb_reg),
    .flush(nb_flush), .halted(nb_halted));

  typedef struct {
    logic [31:0] instr;
    logic [14:0] ctrl;
    logic [3:0]  aluop;
    logic [4:0]  dest;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'h8D090004, 15'h101B, 4'h0, 5'd9};   // LW $9,4($8)
    vt[1]  = '{32'h24080005, 15'h1011, 4'h0, 5'd8};   // ADDIU $8,$0,5
    vt[2]  = '{32'h01085021, 15'h1001, 4'h0, 5'd10};  // ADDU $10,$8,$8
    vt[3]  = '{32'h0C000010, 15'h1281, 4'hF, 5'd31};  // JAL
    vt[4]  = '{32'hAD090008, 15'h1014, 4'h0, 5'd9};   // SW $9,8($8)
    vt[5]  = '{32'h10220003, 15'h1020, 4'h1, 5'd2};   // BEQ $1,$2
    vt[6]  = '{32'h14220003, 15'h1060, 4'h1, 5'd2};   // BNE $1,$2
    vt[7]  = '{32'h342300FF, 15'h0011, 4'h3, 5'd3};   // ORI $3,$1,0xFF
    vt[8]  = '{32'h3C041234, 15'h0411, 4'h3, 5'd4};   // LUI $4,0x1234
    vt[9]  = '{32'h00062880, 15'h1801, 4'h8, 5'd5};   // SLL $5,$6,2
    vt[10] = '{32'h03E00008, 15'h1100, 4'hF, 5'd0};   // JR $31
    vt[11] = '{32'h08000010, 15'h1080, 4'hF, 5'd0};   // J
    vt[12] = '{32'hF8000000, 15'h4000, 4'hF, 5'd0};   // illegal opcode 0x3E
    vt[13] = '{32'h00223823, 15'h1001, 4'h1, 5'd7};   // SUBU $7,$1,$2
    vt[14] = '{32'h3041000F, 15'h0011, 4'h2, 5'd1};   // ANDI $1,$2,0xF
    vt[15] = '{32'hC0430000, 15'h101B, 4'h0, 5'd3};   // LL $3,0($2)
    vt[16] = '{32'h00000000, 15'h0000, 4'hF, 5'd0};   // word 0

    nRST = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
    nb_in_valid = 1'b0; nb_in_instr = '0; nb_out_ready = 1'b1;
    nb_wb_valid = 1'b0; nb_wb_reg = '0; nb_flush = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_aluop", out_aluop, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_halted", halted, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    in_valid = 1'b1; in_instr = 32'h0;
    settle();
    chk("first_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("first_out_valid", out_valid, 1);
    chk("first_out_ctrl", out_ctrl, 0);
    tick();

    // Decode table
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr;
      settle();
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_out_instr", i), out_instr, vt[i].instr);
      chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vt[i].ctrl);
      chk($sformatf("vec%0d_out_aluop", i), out_aluop, vt[i].aluop);
      chk($sformatf("vec%0d_out_dest", i), out_dest, vt[i].dest);
      if (vt[i].ctrl[0] && vt[i].dest != 5'd0) retire(vt[i].dest);
      else tick();
    end

    // RAW hazard with bypass: ADDU accepted in the wb cycle
    in_valid = 1'b1; in_instr = 32'h24080005;
    settle(); chk("haz_addiu_ready", in_ready, 1);
    tick();
    in_instr = 32'h01085021;
    settle(); chk("haz_stall0", in_ready, 0);
    tick();
    settle(); chk("haz_stall1", in_ready, 0);
    wb_valid = 1'b1; wb_reg = 5'd8;
    settle(); chk("haz_bypass_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("haz_out_instr", out_instr, 32'h01085021);
    chk("haz_out_dest", out_dest, 10);
    retire(5'd10);

    // RAW hazard without bypass: ADDU accepted one cycle after wb
    nb_in_valid = 1'b1; nb_in_instr = 32'h24080005;
    settle(); chk("nb_addiu_ready", nb_in_ready, 1);
    tick();
    nb_in_instr = 32'h01085021;
    settle(); chk("nb_stall0", nb_in_ready, 0);
    tick();
    nb_wb_valid = 1'b1; nb_wb_reg = 5'd8;
    settle(); chk("nb_wb_cycle_ready", nb_in_ready, 0);
    tick();
    nb_wb_valid = 1'b0;
    settle(); chk("nb_after_wb_ready", nb_in_ready, 1);
    tick();
    nb_in_valid = 1'b0;
    chk("nb_out_valid", nb_out_valid, 1);
    chk("nb_out_instr", nb_out_instr, 32'h01085021);

    // JAL held while execute back-pressures
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0C000010;
    settle(); chk("jal_ready", in_ready, 1);
    tick();
    chk("jal_dest", out_dest, 31);
    chk("jal_ctrl", out_ctrl, 15'h1281);
    in_instr = 32'h342300FF;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
      chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_out_instr", k), out_instr, 32'h0C000010);
      chk($sformatf("hold%0d_out_dest", k), out_dest, 31);
      tick();
    end
    out_ready = 1'b1;
    settle(); chk("hold_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("hold_next_instr", out_instr, 32'h342300FF);
    retire(5'd31);
    retire(5'd3);

    // Counter saturation on $5 (CNT_W=2 allows three in flight)
    in_valid = 1'b1; in_instr = 32'h24050001;
    for (int k = 0; k < 3; k++) begin
      settle(); chk($sformatf("sat_fill%0d_ready", k), in_ready, 1);
      tick();
    end
    settle(); chk("sat_stall0", in_ready, 0);
    tick();
    settle(); chk("sat_stall1", in_ready, 0);
    wb_valid = 1'b1; wb_reg = 5'd5;
    settle(); chk("sat_retire_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("sat_out_dest", out_dest, 5);
    retire(5'd5); retire(5'd5); retire(5'd5);
    retire(5'd5);  // counter already zero: must not wrap
    in_valid = 1'b1; in_instr = 32'h00A05021;
    settle(); chk("underflow_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("underflow_out_instr", out_instr, 32'h00A05021);
    retire(5'd10);

    // HALT, then flush together with wb
    in_valid = 1'b1; in_instr = 32'h8D090004;
    settle(); chk("halt_lw0_ready", in_ready, 1);
    tick();
    settle(); chk("halt_lw1_ready", in_ready, 1);
    tick();
    in_instr = 32'hFC000000;
    settle(); chk("halt_ready", in_ready, 1);
    tick();
    out_ready = 1'b0; in_instr = 32'h0;
    settle();
    chk("halted_set", halted, 1);
    chk("halt_out_ctrl", out_ctrl, 15'h3000);
    chk("halt_in_ready", in_ready, 0);
    tick();
    settle();
    chk("halt_held_ready", in_ready, 0);
    chk("halt_held_valid", out_valid, 1);
    flush = 1'b1; wb_valid = 1'b1; wb_reg = 5'd9;
    settle(); chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    settle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_halted", halted, 0);
    in_instr = 32'h01294021; out_ready = 1'b1;
    settle(); chk("flush_cnt_clear_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_instr", out_instr, 32'h01294021);
    retire(5'd8);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h24080005;
    settle();
    tick();
    in_valid = 1'b0;
    chk("arst_pre_valid", out_valid, 1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_out_dest", out_dest, 0);
    @(negedge CLK);
    nRST = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h01085021;
    settle(); chk("arst_cnt_clear_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("arst_next_instr", out_instr, 32'h01085021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
